pll_reset_ctrl: RTL and testbench



---
 rtl/pll_reset_ctrl.sv | 144 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a
// stable lock, then releases the system reset; retries on timeout and restarts on lock loss.
module pll_reset_ctrl #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_pll_locked,
   input  logic       i_restart,
   output logic       o_pll_rst,
   output logic       o_sys_rst_n,
   output logic       o_ready,
   output logic       o_fail,
   output logic [7:0] o_lost_count
);

   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RETRY_LAST   = RTY_W'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_WAIT   = 3'd1,
      S_STABLE = 3'd2,
      S_RUN    = 3'd3,
      S_FAIL   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         sync_q, sync_d;
   logic               locked_s;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [7:0]         lost_q, lost_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_n_q, sys_rst_n_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;
   logic               counting;

   // Two-stage synchronizer for the asynchronous lock indication.
   always_comb begin
      sync_d   = {sync_q[0], i_pll_locked};
      locked_s = sync_q[1];
   end

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         S_RESET: begin
            if (cnt_q == RESET_LAST) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_q + RTY_W'(1);
               state_d = (retry_q >= RETRY_LAST) ? S_FAIL : S_RESET;
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_d = S_WAIT;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d = S_RESET;
               if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end
         end
         S_FAIL: begin
            state_d = S_FAIL;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase

      // A restart overrides everything above, including a lost-lock count.
      if (i_restart) begin
         state_d = S_RESET;
         retry_d = '0;
         lost_d  = lost_q;
      end
   end

   always_comb begin
      counting = (state_q == S_RESET) || (state_q == S_WAIT) || (state_q == S_STABLE);
      cnt_d    = '0;
      if (!i_restart && (state_d == state_q) && counting) cnt_d = cnt_q + CNT_W'(1);

      pll_rst_d   = (state_d == S_RESET);
      sys_rst_n_d = (state_d == S_RUN);
      ready_d     = (state_d == S_RUN);
      fail_d      = (state_d == S_FAIL);
   end

   // Outputs are decoded from the next state and registered so they never glitch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_RESET;
         sync_q      <= 2'b00;
         cnt_q       <= '0;
         retry_q     <= '0;
         lost_q      <= 8'd0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lost_q      <= lost_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign o_pll_rst    = pll_rst_q;
   assign o_sys_rst_n  = sys_rst_n_q;
   assign o_ready      = ready_q;
   assign o_fail       = fail_q;
   assign o_lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small timing parameters so every
// phase (reset pulse, lock wait, stable window, retries) is short.
module tb_pll_reset_ctrl;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_pll_locked;
   logic       i_restart;
   logic       o_pll_rst;
   logic       o_sys_rst_n;
   logic       o_ready;
   logic       o_fail;
   logic [7:0] o_lost_count;

   int checks = 0;
   int errors = 0;

   pll_reset_ctrl #(
      .RESET_CYCLES (4),
      .LOCK_TIMEOUT (32),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_pll_locked(i_pll_locked),
      .i_restart   (i_restart),
      .o_pll_rst   (o_pll_rst),
      .o_sys_rst_n (o_sys_rst_n),
      .o_ready     (o_ready),
      .o_fail      (o_fail),
      .o_lost_count(o_lost_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic locked, input logic restart);
      i_pll_locked = locked;
      i_restart    = restart;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pll_rst"}, o_pll_rst, 1);
      checkOutput({tag, "_sys_rst_n"}, o_sys_rst_n, 0);
      checkOutput({tag, "_ready"}, o_ready, 0);
      checkOutput({tag, "_fail"}, o_fail, 0);
      checkOutput({tag, "_lost"}, o_lost_count, 0);
   endtask

   task automatic waitReady(input string tag);
      int budget = 0;
      while (o_ready !== 1'b1 && budget < 200) begin
         tick(1);
         budget++;
      end
      checkOutput(tag, o_ready, 1);
   endtask

   initial begin
      i_rst_n = 1'b0;
      applyStimulus(0, 0);
      tick(2);
      $display("[TB] reset values");
      checkResetValues("rst");
      i_rst_n = 1'b1;

      $display("[TB] scenario 1: nominal lock");
      checkOutput("s1_pll_rst_at_release", o_pll_rst, 1);
      tick(3);
      checkOutput("s1_pll_rst_edge3", o_pll_rst, 1);
      tick(1);
      checkOutput("s1_pll_rst_fall_edge4", o_pll_rst, 0);
      tick(5);
      applyStimulus(1, 0);
      tick(10);
      checkOutput("s1_ready_early", o_ready, 0);
      checkOutput("s1_sys_rst_n_early", o_sys_rst_n, 0);
      tick(1);
      checkOutput("s1_ready", o_ready, 1);
      checkOutput("s1_sys_rst_n", o_sys_rst_n, 1);
      checkOutput("s1_fail", o_fail, 0);
      checkOutput("s1_pll_rst_low", o_pll_rst, 0);

      $display("[TB] scenario 2: lock glitch in stable window");
      applyStimulus(1, 1);
      tick(1);
      applyStimulus(1, 0);
      checkOutput("s2_restart_pll_rst", o_pll_rst, 1);
      checkOutput("s2_restart_ready", o_ready, 0);
      tick(4);
      checkOutput("s2_wait_pll_rst", o_pll_rst, 0);
      tick(6);
      applyStimulus(0, 0);
      tick(3);
      checkOutput("s2_glitch_sys_rst_n", o_sys_rst_n, 0);
      checkOutput("s2_glitch_ready", o_ready, 0);
      checkOutput("s2_glitch_pll_rst", o_pll_rst, 0);
      applyStimulus(1, 0);
      tick(10);
      checkOutput("s2_ready_early", o_ready, 0);
      tick(1);
      checkOutput("s2_ready", o_ready, 1);

      $display("[TB] scenario 4: single lock loss in run");
      applyStimulus(0, 0);
      tick(2);
      checkOutput("s4_sys_rst_n_hold", o_sys_rst_n, 1);
      tick(1);
      checkOutput("s4_sys_rst_n", o_sys_rst_n, 0);
      checkOutput("s4_pll_rst", o_pll_rst, 1);
      checkOutput("s4_ready", o_ready, 0);
      checkOutput("s4_lost_1", o_lost_count, 1);

      $display("[TB] scenario 5: lock loss and restart together");
      applyStimulus(1, 0);
      waitReady("s5_reach_run");
      applyStimulus(0, 0);
      tick(2);
      applyStimulus(0, 1);
      tick(1);
      applyStimulus(0, 0);
      checkOutput("s5_pll_rst", o_pll_rst, 1);
      checkOutput("s5_ready", o_ready, 0);
      checkOutput("s5_lost_unchanged", o_lost_count, 1);

      $display("[TB] scenario 4b: lost count saturation");
      for (int n = 2; n <= 300; n++) begin
         applyStimulus(1, 0);
         waitReady("s4b_reach_run");
         applyStimulus(0, 0);
         tick(3);
         if (n == 2 || n == 254 || n == 255 || n == 256 || n == 300)
            checkOutput($sformatf("s4b_lost_%0d", n), o_lost_count, (n > 255) ? 255 : n);
      end

      $display("[TB] scenario 6a: async reset in stable window");
      applyStimulus(1, 1);
      tick(1);
      applyStimulus(1, 0);
      tick(7);
      checkOutput("s6a_pre_pll_rst", o_pll_rst, 0);
      checkOutput("s6a_pre_lost", o_lost_count, 255);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkResetValues("s6a");

      $display("[TB] scenario 3: timeout retries and fail");
      applyStimulus(0, 0);
      tick(2);
      i_rst_n = 1'b1;
      tick(3);
      checkOutput("s3_pulse1_high", o_pll_rst, 1);
      tick(1);
      checkOutput("s3_pulse1_fall", o_pll_rst, 0);
      tick(31);
      checkOutput("s3_wait1_end", o_pll_rst, 0);
      tick(1);
      checkOutput("s3_pulse2_rise", o_pll_rst, 1);
      tick(3);
      checkOutput("s3_pulse2_high", o_pll_rst, 1);
      tick(1);
      checkOutput("s3_pulse2_fall", o_pll_rst, 0);
      tick(31);
      checkOutput("s3_fail_early", o_fail, 0);
      tick(1);
      checkOutput("s3_fail", o_fail, 1);
      checkOutput("s3_fail_pll_rst", o_pll_rst, 0);
      checkOutput("s3_fail_sys_rst_n", o_sys_rst_n, 0);
      checkOutput("s3_fail_ready", o_ready, 0);
      tick(5);
      checkOutput("s3_fail_sticky", o_fail, 1);
      applyStimulus(0, 1);
      tick(1);
      applyStimulus(0, 0);
      checkOutput("s3_restart_fail", o_fail, 0);
      checkOutput("s3_restart_pll_rst", o_pll_rst, 1);
      tick(71);
      checkOutput("s3_refail_early", o_fail, 0);
      tick(1);
      checkOutput("s3_refail", o_fail, 1);

      $display("[TB] scenario 6b: async reset in fail");
      #2;
      i_rst_n = 1'b0;
      #1;
      checkResetValues("s6b");
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
